// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// serial_subtractor_pkg : shared constants for the adder-family blocks
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_fulladder.sv
// ============================================================================
// fulladder : 1-bit full adder cell shared by the adder-family datapaths
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial diff = a - b - b_in using one fulladder cell
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;
  logic             b_inv;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  // Subtraction as a + ~b + ~b_in; the carry register holds the inverted borrow.
  assign b_inv    = ~b_sh[0];
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  fulladder u_fa (
    .a     (a_sh[0]),
    .b     (b_inv),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      b_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= ~b_in;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          diff  <= {fa_sum, diff[WIDTH-1:1]};
          if (last_bit) begin
            // fa_sum is the result MSB here, so flags settle on the same edge.
            b_out <= ~fa_cout;
            ovf   <= (a_msb ^ b_msb) & (fa_sum ^ a_msb);
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : table-driven scoreboard bench for serial_subtractor
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         ready;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
  logic         ovf;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  vec_t cur_exp;
  vec_t tbl[8];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .ready (ready),
    .done  (done),
    .diff  (diff),
    .b_out (b_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Accepted starts push the expected result with the accepting edge number.
  always @(posedge clk) begin
    cyc++;
    if (!rst && start && ready)
      sb.push_back('{diff: cur_exp.diff, b_out: cur_exp.b_out, ovf: cur_exp.ovf, acc_cyc: cyc});
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("diff", int'(diff), int'(e.diff));
          check("b_out", int'(b_out), int'(e.b_out));
          check("ovf", int'(ovf), int'(e.ovf));
          check("done_latency", cyc, e.acc_cyc + W);
        end
      end else if (sb.size() > 0 && cyc > sb[0].acc_cyc + W) begin
        check("missed_done", cyc, sb[0].acc_cyc + W);
        void'(sb.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", int'(ready), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic launch(input vec_t v);
    wait_ready();
    cur_exp = v;
    a       = v.a;
    b       = v.b;
    b_in    = v.b_in;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int snap;
    tbl[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1};
    tbl[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1};
    tbl[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0};
    tbl[3] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
    tbl[4] = '{4'h5, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[5] = '{4'h7, 4'hF, 1'b1, 4'h7, 1'b1, 1'b0};
    tbl[6] = '{4'h4, 4'hC, 1'b0, 4'h8, 1'b1, 1'b1};
    tbl[7] = '{4'h8, 4'h0, 1'b1, 4'h7, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_b_out", int'(b_out), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      launch(tbl[i]);
      wait_idle();
      @(negedge clk);
    end

    // Operands changed while RUN must not disturb the captured values.
    launch(tbl[3]);
    for (int k = 0; k < W; k++) begin
      a = 4'(k * 5 + 2); b = 4'(k * 3 + 11); b_in = ~b_in;
      @(negedge clk);
    end
    wait_idle();

    // start pulses during RUN and DONE are ignored.
    launch(tbl[1]);
    snap = done_cnt;
    for (int i = 0; i <= W; i++) begin
      check("busy_ready", int'(ready), 0);
      start = (i % 2 == 0) || (i == W);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    check("single_done", done_cnt - snap, 1);

    // start held high for 20 cycles: accepts every W+2 cycles.
    wait_ready();
    snap    = done_cnt;
    cur_exp = tbl[6];
    a = tbl[6].a; b = tbl[6].b; b_in = tbl[6].b_in;
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("held_start_dones", done_cnt - snap, 4);

    // Asynchronous reset two cycles into RUN.
    launch(tbl[0]);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("arst_ready", int'(ready), 1);
    check("arst_done", int'(done), 0);
    check("arst_diff", int'(diff), 0);
    check("arst_b_out", int'(b_out), 0);
    check("arst_ovf", int'(ovf), 0);
    snap = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("arst_no_done", done_cnt - snap, 0);
    launch(tbl[4]);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
